mem_ctrl: RTL and testbench

Load/store initiator sitting between the MEM pipeline stage and the byte-lane data memory (`dm_*` interface). Accepts one load or store request at a time over a valid/ready handshake and checks alignment. Drives word-aligned address, byte enables and lane-replicated write data to the memory. Captures and extends load data, then returns it with a valid/ready response.

---
 rtl/mem_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: single-outstanding load/store initiator between the MEM stage and
// a byte-lane data memory. Checks alignment, drives one memory cycle, then
// returns extended load data (or an address exception) over valid/ready.
module mem_ctrl #(
  parameter logic [4:0] EXC_ADEL = 5'd4,
  parameter logic [4:0] EXC_ADES = 5'd5
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_exc,
  output logic [4:0]  resp_exc_code,
  output logic        dm_en,
  output logic [3:0]  dm_byte,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_in,
  input  logic [31:0] dm_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t      state_q, state_d;
  req_t        req_q, req_d;
  logic        dm_en_q, dm_en_d;
  logic [3:0]  dm_byte_q, dm_byte_d;
  logic [31:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_in_q, dm_in_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_exc_q, resp_exc_d;
  logic [4:0]  resp_code_q, resp_code_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        misal;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  // Alignment check, store lane mask / replicated data, load extraction
  always_comb begin
    misal     = 1'b0;
    lane_mask = 4'b0000;
    lane_data = req_wdata;
    case (req_size)
      2'b00: begin
        lane_mask = 4'b0001 << req_addr[1:0];
        lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misal     = req_addr[0];
        lane_mask = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        misal     = |req_addr[1:0];
        lane_mask = 4'b1111;
      end
      default: misal = 1'b1;
    endcase

    // Memory returns the whole word; move the addressed byte/half to bit 0
    rd_shift = dm_out >> {req_q.addr[1:0], 3'b000};
    case (req_q.size)
      2'b00:   rd_ext = {{24{req_q.sgn & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   rd_ext = {{16{req_q.sgn & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  // Next-state and registered-output logic; dm strobes default low so they
  // are only ever high for the single ACCESS cycle
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    dm_en_d      = 1'b0;
    dm_byte_d    = 4'b0000;
    dm_in_d      = 32'h0;
    dm_addr_d    = dm_addr_q;
    resp_valid_d = resp_valid_q;
    resp_exc_d   = resp_exc_q;
    resp_code_d  = resp_code_q;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d = '{we: req_we, size: req_size, sgn: req_signed,
                    addr: req_addr, wdata: req_wdata};
          if (misal) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_exc_d   = 1'b1;
            resp_code_d  = req_we ? EXC_ADES : EXC_ADEL;
            resp_rdata_d = 32'h0;
          end else begin
            state_d   = ACCESS;
            dm_en_d   = 1'b1;
            dm_addr_d = {req_addr[31:2], 2'b00};
            dm_byte_d = req_we ? lane_mask : 4'b0000;
            dm_in_d   = lane_data;
          end
        end
      end
      ACCESS: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_exc_d   = 1'b0;
        resp_code_d  = 5'd0;
        resp_rdata_d = req_q.we ? 32'h0 : rd_ext;
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      req_q        <= '0;
      dm_en_q      <= 1'b0;
      dm_byte_q    <= 4'b0000;
      dm_addr_q    <= 32'h0;
      dm_in_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_exc_q   <= 1'b0;
      resp_code_q  <= 5'd0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      dm_en_q      <= dm_en_d;
      dm_byte_q    <= dm_byte_d;
      dm_addr_q    <= dm_addr_d;
      dm_in_q      <= dm_in_d;
      resp_valid_q <= resp_valid_d;
      resp_exc_q   <= resp_exc_d;
      resp_code_q  <= resp_code_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready     = resetn && (state_q == IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_exc      = resp_exc_q;
  assign resp_exc_code = resp_code_q;
  assign dm_en         = dm_en_q;
  assign dm_byte       = dm_byte_q;
  assign dm_addr       = dm_addr_q;
  assign dm_in         = dm_in_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a byte-lane memory attached to dm_*, a directed vector
// table, hand-written backpressure/reset sequences, and random traffic
// checked against a byte-array reference model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        resp_ready = 1'b0;
  logic        req_ready, resp_valid, resp_exc, dm_en;
  logic [31:0] resp_rdata, dm_addr, dm_in, dm_out;
  logic [4:0]  resp_exc_code;
  logic [3:0]  dm_byte;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_exc(resp_exc), .resp_exc_code(resp_exc_code),
    .dm_en(dm_en), .dm_byte(dm_byte), .dm_addr(dm_addr), .dm_in(dm_in),
    .dm_out(dm_out)
  );

  // Attached memory: 64 words, aliased on addr[7:2], combinational read
  logic [31:0] mem [64];
  logic        clr_mem = 1'b1;
  assign dm_out = mem[dm_addr[7:2]];
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (dm_en) begin
      for (int b = 0; b < 4; b++)
        if (dm_byte[b]) mem[dm_addr[7:2]][8*b +: 8] <= dm_in[8*b +: 8];
    end
  end

  // Reference model: flat byte array, little-endian, same 256-byte aliasing
  logic [7:0] ref_mem [256];

  task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic exc,
                       output logic [4:0] code, output logic [3:0] byt,
                       output logic [31:0] din);
    int n;
    logic [31:0] v;
    rd = 32'h0; exc = 1'b0; code = 5'd0; byt = 4'h0; din = 32'h0;
    n = 1 << sz;
    if (sz == 2'd3 || (a % n) != 0) begin
      exc  = 1'b1;
      code = we ? 5'd5 : 5'd4;
      return;
    end
    for (int b = 0; b < 4; b++) din[8*b +: 8] = wd[8*(b % n) +: 8];
    if (we) begin
      for (int i = 0; i < n; i++) begin
        ref_mem[(a + i) % 256] = wd[8*i +: 8];
        byt[(a % 4) + i] = 1'b1;
      end
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[(a + i) % 256];
      if (sg && n < 4 && v[8*n-1]) for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      rd = v;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    logic        exc;
    logic [4:0]  code;
    logic        saw_en;
    logic [3:0]  byt;
    logic [31:0] din;
    logic [31:0] daddr;
    int          lat;
  } obs_t;

  // One full transaction; request fields are scrambled right after the
  // accepting edge so any late sampling of req_* shows up as a mismatch
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, output obs_t o);
    int n;
    o = '{rd: 32'h0, exc: 1'b0, code: 5'd0, saw_en: 1'b0, byt: 4'h0,
          din: 32'h0, daddr: 32'h0, lat: 0};
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    while (!resp_valid && n < 10) begin
      if (dm_en) begin
        o.saw_en = 1'b1; o.byt = dm_byte; o.din = dm_in; o.daddr = dm_addr;
      end
      @(posedge clk); #1; n++;
    end
    if (dm_en) o.saw_en = 1'b1;
    o.lat = n;
    chk("resp_timeout", {31'h0, resp_valid}, 32'h1);
    o.rd = resp_rdata; o.exc = resp_exc; o.code = resp_exc_code;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic check_obs(input string tag, input obs_t o, input logic we,
                           input logic [31:0] a, input logic [31:0] e_rd,
                           input logic e_exc, input logic [4:0] e_code,
                           input logic [3:0] e_byt, input logic [31:0] e_din);
    chk({tag, ".rdata"}, o.rd, e_rd);
    chk({tag, ".exc"}, {31'h0, o.exc}, {31'h0, e_exc});
    chk({tag, ".code"}, {27'h0, o.code}, {27'h0, e_code});
    chk({tag, ".dm_en"}, {31'h0, o.saw_en}, {31'h0, !e_exc});
    if (!e_exc) begin
      chk({tag, ".latency"}, o.lat, 32'd1);
      chk({tag, ".dm_byte"}, {28'h0, o.byt}, {28'h0, e_byt});
      chk({tag, ".dm_addr"}, o.daddr, {a[31:2], 2'b00});
      if (we) chk({tag, ".dm_in"}, o.din, e_din);
    end else begin
      chk({tag, ".latency"}, o.lat, 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req_ready"}, {31'h0, req_ready}, 32'h0);
    chk({tag, ".resp_valid"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, ".resp_exc"}, {31'h0, resp_exc}, 32'h0);
    chk({tag, ".resp_code"}, {27'h0, resp_exc_code}, 32'h0);
    chk({tag, ".resp_rdata"}, resp_rdata, 32'h0);
    chk({tag, ".dm_en"}, {31'h0, dm_en}, 32'h0);
    chk({tag, ".dm_byte"}, {28'h0, dm_byte}, 32'h0);
    chk({tag, ".dm_addr"}, dm_addr, 32'h0);
    chk({tag, ".dm_in"}, dm_in, 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a, wd, rd;
    logic        exc;
    logic [4:0]  code;
    logic [3:0]  byt;
    logic [31:0] din;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    logic [31:0] e_rd, e_din, snap;
    logic        e_exc;
    logic [4:0]  e_code;
    logic [3:0]  e_byt;
    int          n;

    //                we    sz     sg    addr        wdata         rdata         exc   code  byt      din
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 5'd0, 4'hF, 32'hDEADBEEF};
    tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 5'd0, 4'h0, 32'h0};
    tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 32'h0,        1'b0, 5'd0, 4'h8, 32'hA5A5A5A5};
    tbl[3]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'hFFFFFFA5, 1'b0, 5'd0, 4'h0, 32'h0};
    tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'h000000A5, 1'b0, 5'd0, 4'h0, 32'h0};
    tbl[5]  = '{1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, 32'h0,        1'b0, 5'd0, 4'hC, 32'h80018001};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        32'hFFFF8001, 1'b0, 5'd0, 4'h0, 32'h0};
    tbl[7]  = '{1'b0, 2'd1, 1'b0, 32'h22, 32'h0,        32'h00008001, 1'b0, 5'd0, 4'h0, 32'h0};
    tbl[8]  = '{1'b0, 2'd2, 1'b0, 32'h21, 32'h0,        32'h0,        1'b1, 5'd4, 4'h0, 32'h0};
    tbl[9]  = '{1'b1, 2'd1, 1'b0, 32'h23, 32'h0000FFFF, 32'h0,        1'b1, 5'd5, 4'h0, 32'h0};
    tbl[10] = '{1'b0, 2'd3, 1'b0, 32'h30, 32'h0,        32'h0,        1'b1, 5'd4, 4'h0, 32'h0};
    tbl[11] = '{1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFFFFFF, 32'h0,        1'b1, 5'd5, 4'h0, 32'h0};
    tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'h80010000, 1'b0, 5'd0, 4'h0, 32'h0};

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    resetn = 1'b1; clr_mem = 1'b0;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      do_req(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, o);
      model(tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd,
            e_rd, e_exc, e_code, e_byt, e_din);
      check_obs($sformatf("vec%0d", i), o, tbl[i].we, tbl[i].a, tbl[i].rd,
                tbl[i].exc, tbl[i].code, tbl[i].byt, tbl[i].din);
    end

    // Backpressure: response held 5 cycles with a second request waiting
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0; req_addr = 32'h13;
    n = 0;
    while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    model(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, e_rd, e_exc, e_code, e_byt, e_din);
    snap = e_rd;
    for (int c = 0; c < 5; c++) begin
      chk("bp.resp_valid", {31'h0, resp_valid}, 32'h1);
      chk("bp.rdata", resp_rdata, snap);
      chk("bp.req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp.ready_after", {31'h0, req_ready}, 32'h1);
    chk("bp.not_yet", {31'h0, dm_en}, 32'h0);
    chk("bp.valid_drop", {31'h0, resp_valid}, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp.accepted", {31'h0, dm_en}, 32'h1);
    chk("bp.acc_addr", dm_addr, 32'h10);
    n = 0;
    while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    model(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, e_rd, e_exc, e_code, e_byt, e_din);
    chk("bp.second_rdata", resp_rdata, e_rd);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;

    // Reset during ACCESS of a word store: memory still written, no response
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h12345678;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstacc.dm_en", {31'h0, dm_en}, 32'h1);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("rstacc");
    model(1'b1, 2'd2, 1'b0, 32'h40, 32'h12345678, e_rd, e_exc, e_code, e_byt, e_din);
    @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("rstacc.no_resp", {31'h0, resp_valid}, 32'h0);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, o);
    chk("rstacc.mem", o.rd, 32'h12345678);

    // Reset during RESP: pending response dropped
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h40;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("rstresp.valid_before", {31'h0, resp_valid}, 32'h1);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("rstresp.valid", {31'h0, resp_valid}, 32'h0);
    chk("rstresp.rdata", resp_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    // Random traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      logic        we, sg;
      logic [1:0]  sz;
      logic [31:0] a, wd;
      we = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom);
      a = $urandom; wd = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      do_req(we, sz, sg, a, wd, o);
      model(we, sz, sg, a, wd, e_rd, e_exc, e_code, e_byt, e_din);
      check_obs($sformatf("rnd%0d", i), o, we, a, e_rd, e_exc, e_code, e_byt, e_din);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
